// File: rtl/multicore_trace_monitor_pkg.sv
// Shared types and constants for the multicore trace monitor: event
// encoding, l.nop opcode/K values and the FIFO entry layout.
package multicore_trace_monitor_pkg;

  typedef enum logic [1:0] {
    EVT_EXIT    = 2'd0,
    EVT_PUTC    = 2'd1,
    EVT_REPORT  = 2'd2,
    EVT_TIMEOUT = 2'd3
  } evt_type_e;

  localparam logic [7:0]  NOP_OPCODE   = 8'h15;
  localparam logic [15:0] NOP_K_EXIT   = 16'd1;
  localparam logic [15:0] NOP_K_REPORT = 16'd2;
  localparam logic [15:0] NOP_K_PUTC   = 16'd4;

  localparam logic [4:0]  SHADOW_REG   = 5'd3;

  typedef struct packed {
    evt_type_e   etype;
    logic [31:0] data;
  } trace_evt_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Per-core event FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is discarded by the FIFO and the
// caller flags the drop.
module trace_event_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/multicore_trace_monitor.sv
// Multicore trace monitor: decodes l.nop simulation hooks on each core's
// retire stream, queues EXIT/PUTC/REPORT events per core, and serves them
// round-robin on a single valid/ready event port with an idle watchdog.
module multicore_trace_monitor
  import multicore_trace_monitor_pkg::*;
#(
  parameter int NUM_CORES      = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TERM_CROSS_NUM = NUM_CORES,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CORES-1:0]   trace_valid,
  input  logic [NUM_CORES*32-1:0] trace_insn,
  input  logic [NUM_CORES-1:0]   trace_wben,
  input  logic [NUM_CORES*5-1:0] trace_wbreg,
  input  logic [NUM_CORES*32-1:0] trace_wbdata,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CW-1:0]          evt_core,
  output logic [1:0]             evt_type,
  output logic [31:0]            evt_data,
  output logic [NUM_CORES-1:0]   core_terminated,
  output logic [NUM_CORES-1:0]   overflow,
  output logic                   all_done,
  output logic                   timeout
);

  trace_evt_t [NUM_CORES-1:0] fifo_head;
  logic [NUM_CORES-1:0] fifo_full;
  logic [NUM_CORES-1:0] fifo_empty;
  logic [NUM_CORES-1:0] fifo_pop;
  logic [NUM_CORES-1:0] cap_busy;
  logic [NUM_CORES-1:0] cap_exit;

  logic [CW-1:0] last_grant;
  logic [CW-1:0] rr_idx;
  logic          rr_found;
  logic [CW-1:0] gnt_idx;
  logic          gnt_to;
  logic          lock_q;
  logic          lock_to_q;
  logic [CW-1:0] lock_idx_q;
  logic          pop_core;
  logic          pop_to;

  logic [31:0]   wd_cnt;
  logic          to_valid;
  logic [31:0]   to_data;
  logic          any_retire;
  int            term_cnt;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic [7:0]  opcode;
    logic [15:0] k;
    logic [7:0]  insn_unused;
    logic        retire;
    logic        hit;
    evt_type_e   det_type;
    logic [31:0] r3;
    logic        cap_valid;
    trace_evt_t  cap_evt;

    assign opcode      = trace_insn[g*32+24 +: 8];
    assign k           = trace_insn[g*32 +: 16];
    assign insn_unused = trace_insn[g*32+16 +: 8];
    // A pending EXIT in the capture stage already ends the core's trace.
    assign retire      = trace_valid[g] && !core_terminated[g] && !cap_exit[g];
    assign cap_busy[g] = cap_valid;
    assign cap_exit[g] = cap_valid && (cap_evt.etype == EVT_EXIT);

    // Decode the l.nop hook number into an event type.
    always_comb begin
      hit      = 1'b0;
      det_type = EVT_PUTC;
      if (opcode == NOP_OPCODE) begin
        case (k)
          NOP_K_EXIT:   begin hit = 1'b1; det_type = EVT_EXIT;   end
          NOP_K_PUTC:   begin hit = 1'b1; det_type = EVT_PUTC;   end
          NOP_K_REPORT: begin hit = 1'b1; det_type = EVT_REPORT; end
          default:      begin hit = 1'b0; det_type = EVT_PUTC;   end
        endcase
      end
    end

    // Shadow r3 and capture stage; payload uses r3 before this cycle's write-back.
    always_ff @(posedge clk) begin
      if (rst) begin
        r3        <= '0;
        cap_valid <= 1'b0;
        cap_evt   <= '0;
      end else begin
        if (retire && trace_wben[g] && (trace_wbreg[g*5 +: 5] == SHADOW_REG))
          r3 <= trace_wbdata[g*32 +: 32];
        cap_valid <= retire && hit;
        if (retire && hit) begin
          cap_evt.etype <= det_type;
          cap_evt.data  <= (det_type == EVT_PUTC) ? {24'h0, r3[7:0]} : r3;
        end
      end
    end

    trace_event_fifo #(
      .WIDTH ($bits(trace_evt_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cap_valid),
      .push_data (cap_evt),
      .pop       (fifo_pop[g]),
      .pop_data  (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  // Round-robin search starting after the last served core.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int n = 1; n <= NUM_CORES; n++) begin
      idx = int'(last_grant) + n;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!rr_found && !fifo_empty[CW'(idx)]) begin
        rr_found = 1'b1;
        rr_idx   = CW'(idx);
      end
    end
  end

  // Grant selection; a stalled grant is frozen so the event port stays stable.
  always_comb begin
    gnt_to  = 1'b0;
    gnt_idx = '0;
    if (lock_q) begin
      gnt_to  = lock_to_q;
      gnt_idx = lock_idx_q;
    end else if (rr_found) begin
      gnt_idx = rr_idx;
    end else begin
      gnt_to  = to_valid;
    end
  end

  // Event port drive and pop decode.
  always_comb begin
    evt_valid = (|(~fifo_empty)) || to_valid;
    evt_core  = gnt_to ? '0 : gnt_idx;
    evt_type  = gnt_to ? EVT_TIMEOUT : fifo_head[gnt_idx].etype;
    evt_data  = gnt_to ? to_data : fifo_head[gnt_idx].data;
    pop_core  = evt_valid && evt_ready && !gnt_to;
    pop_to    = evt_valid && evt_ready && gnt_to;
    fifo_pop  = '0;
    if (pop_core) fifo_pop[gnt_idx] = 1'b1;
  end

  // Arbiter state: last served core and stall lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CW'(NUM_CORES - 1);
      lock_q     <= 1'b0;
      lock_to_q  <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= evt_valid && !evt_ready;
      lock_to_q  <= gnt_to;
      lock_idx_q <= gnt_idx;
      if (pop_core) last_grant <= gnt_idx;
    end
  end

  // Sticky exit and drop flags, updated in the push cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_terminated <= '0;
      overflow        <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (cap_exit[i]) core_terminated[i] <= 1'b1;
        if (cap_busy[i] && fifo_full[i] && !fifo_pop[i]) overflow[i] <= 1'b1;
      end
    end
  end

  assign any_retire = |trace_valid;

  // Idle watchdog with a single-entry, lowest-priority TIMEOUT slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      timeout  <= 1'b0;
      to_valid <= 1'b0;
      to_data  <= '0;
    end else begin
      if (pop_to) to_valid <= 1'b0;
      if (TIMEOUT_CYCLES > 0) begin
        if (any_retire)          wd_cnt <= '0;
        else if (wd_cnt != '1)   wd_cnt <= wd_cnt + 1'b1;
        if (!timeout && !any_retire && (wd_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
          timeout  <= 1'b1;
          to_valid <= 1'b1;
          to_data  <= wd_cnt + 1'b1;
        end
      end
    end
  end

  // Count of exited cores for the termination criterion.
  always_comb begin
    term_cnt = 0;
    for (int i = 0; i < NUM_CORES; i++)
      term_cnt = term_cnt + (core_terminated[i] ? 1 : 0);
  end

  // Registered completion flag: enough exits and nothing left in flight.
  always_ff @(posedge clk) begin
    if (rst) all_done <= 1'b0;
    else     all_done <= (term_cnt >= TERM_CROSS_NUM) && (&fifo_empty) &&
                         !(|cap_busy) && !evt_valid;
  end

endmodule

// File: tb/tb_multicore_trace_monitor.sv
// Directed bench for multicore_trace_monitor: a per-cycle vector table on
// core 0 plus hand-written multi-cycle sequences.
module tb_multicore_trace_monitor;

  localparam int NC = 4;

  localparam logic [31:0] INSN_ADDI   = 32'h9c600000;
  localparam logic [31:0] NOP_EXIT    = 32'h15000001;
  localparam logic [31:0] NOP_REPORT  = 32'h15000002;
  localparam logic [31:0] NOP_PUTC    = 32'h15000004;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    trace_valid;
  logic [NC*32-1:0] trace_insn;
  logic [NC-1:0]    trace_wben;
  logic [NC*5-1:0]  trace_wbreg;
  logic [NC*32-1:0] trace_wbdata;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_core;
  logic [1:0]       evt_type;
  logic [31:0]      evt_data;
  logic [NC-1:0]    core_terminated;
  logic [NC-1:0]    overflow;
  logic             all_done;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  multicore_trace_monitor #(
    .NUM_CORES      (NC),
    .FIFO_DEPTH     (4),
    .TERM_CROSS_NUM (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trace_valid     (trace_valid),
    .trace_insn      (trace_insn),
    .trace_wben      (trace_wben),
    .trace_wbreg     (trace_wbreg),
    .trace_wbdata    (trace_wbdata),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_core        (evt_core),
    .evt_type        (evt_type),
    .evt_data        (evt_data),
    .core_terminated (core_terminated),
    .overflow        (overflow),
    .all_done        (all_done),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] insn;
    logic        wben;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        rdy;
    logic        ev;
    logic [1:0]  et;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    trace_valid  = '0;
    trace_insn   = '0;
    trace_wben   = '0;
    trace_wbreg  = '0;
    trace_wbdata = '0;
  endtask

  task automatic drv(input int c, input logic [31:0] insn, input logic wben,
                     input logic [4:0] wreg, input logic [31:0] wdata);
    trace_valid[c]           = 1'b1;
    trace_insn[c*32 +: 32]   = insn;
    trace_wben[c]            = wben;
    trace_wbreg[c*5 +: 5]    = wreg;
    trace_wbdata[c*32 +: 32] = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt_ready = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for an event, compare it, then consume it with ready=1.
  task automatic expect_event(input string nm, input logic [1:0] c,
                              input logic [1:0] t, input logic [31:0] d);
    int n;
    n = 0;
    evt_ready = 1'b1;
    while (!evt_valid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_valid"}, evt_valid, 1);
    check({nm, "_core"}, evt_core, c);
    check({nm, "_type"}, evt_type, t);
    check({nm, "_data"}, evt_data, d);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int extra;
    int n;

    //                v     insn          wben  wreg  wdata          rdy   ev    et    ed
    tbl[0]  = '{1'b1, 32'h9c600041, 1'b1, 5'd3, 32'h00000041, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{1'b1, NOP_PUTC,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 2'd1, 32'h41};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[4]  = '{1'b1, NOP_PUTC,     1'b1, 5'd3, 32'h12345655, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[5]  = '{1'b1, NOP_REPORT,   1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'd1, 32'h41};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'd1, 32'h41};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 2'd2, 32'h12345655};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[9]  = '{1'b1, 32'h15000003, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[11] = '{1'b1, 32'h14000004, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};
    tbl[13] = '{1'b1, 32'h9c8000ff, 1'b1, 5'd4, 32'h000000ff, 1'b1, 1'b0, 2'd0, 32'h0};
    tbl[14] = '{1'b1, NOP_PUTC,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 2'd0, 32'h0};
    tbl[15] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 2'd1, 32'h55};
    tbl[16] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 2'd0, 32'h0};

    // Reset state
    do_reset();
    check("rst_evt_valid", evt_valid, 0);
    check("rst_core_terminated", core_terminated, 0);
    check("rst_overflow", overflow, 0);
    check("rst_all_done", all_done, 0);
    check("rst_timeout", timeout, 0);

    // Single-core vector table on core 0
    for (int i = 0; i < 17; i++) begin
      clear_inputs();
      evt_ready = tbl[i].rdy;
      if (tbl[i].v) drv(0, tbl[i].insn, tbl[i].wben, tbl[i].wreg, tbl[i].wdata);
      step();
      check($sformatf("vec%0d_valid", i), evt_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_core", i), evt_core, 0);
        check($sformatf("vec%0d_type", i), evt_type, tbl[i].et);
        check($sformatf("vec%0d_data", i), evt_data, tbl[i].ed);
      end
      check($sformatf("vec%0d_all_done", i), all_done, 0);
    end
    clear_inputs();

    // All four cores PUTC together: served 0,1,2,3 on consecutive cycles
    do_reset();
    evt_ready = 1'b1;
    for (int c = 0; c < NC; c++) drv(c, INSN_ADDI, 1'b1, 5'd3, 32'h10 + c);
    step();
    clear_inputs();
    for (int c = 0; c < NC; c++) drv(c, NOP_PUTC, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    step();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("rr%0d_valid", c), evt_valid, 1);
      check($sformatf("rr%0d_core", c), evt_core, c);
      check($sformatf("rr%0d_data", c), evt_data, 32'h10 + c);
      step();
    end
    check("rr_drained", evt_valid, 0);

    // Stall for 10 cycles: grant on core 2 holds although core 0 becomes ready
    do_reset();
    drv(2, INSN_ADDI, 1'b1, 5'd3, 32'hBB);
    step();
    clear_inputs();
    drv(2, NOP_PUTC, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    step();
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      if (i == 0) drv(0, INSN_ADDI, 1'b1, 5'd3, 32'hAA);
      if (i == 1) drv(0, NOP_PUTC, 1'b0, 5'd0, 32'h0);
      step();
      check($sformatf("stall%0d_valid", i), evt_valid, 1);
      check($sformatf("stall%0d_core", i), evt_core, 2);
      check($sformatf("stall%0d_data", i), evt_data, 32'hBB);
    end
    clear_inputs();
    evt_ready = 1'b1;
    step();
    check("stall_next_core", evt_core, 0);
    check("stall_next_data", evt_data, 32'hAA);
    step();
    check("stall_drained", evt_valid, 0);

    // Overflow: five PUTC on core 2 into a depth-4 FIFO with ready low
    do_reset();
    drv(2, INSN_ADDI, 1'b1, 5'd3, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      drv(2, NOP_PUTC, 1'b1, 5'd3, 32'(k + 1));
      step();
    end
    clear_inputs();
    step();
    step();
    check("ovf_flag", overflow, 4'b0100);
    for (int k = 0; k < 4; k++)
      expect_event($sformatf("ovf_drain%0d", k), 2'd2, 2'd1, 32'(k));
    step();
    check("ovf_drained", evt_valid, 0);
    check("ovf_sticky", overflow, 4'b0100);

    // Push and pop on a full FIFO in the same cycle both succeed
    do_reset();
    drv(0, INSN_ADDI, 1'b1, 5'd3, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      drv(0, NOP_PUTC, 1'b1, 5'd3, 32'(k + 1));
      step();
    end
    clear_inputs();
    evt_ready = 1'b1;
    step();
    check("fullpp_overflow", overflow, 0);
    for (int k = 1; k < 5; k++)
      expect_event($sformatf("fullpp%0d", k), 2'd0, 2'd1, 32'(k));
    check("fullpp_drained", evt_valid, 0);

    // EXIT on cores 1 and 3; later core-1 retires ignored; all_done after drain
    do_reset();
    evt_ready = 1'b1;
    drv(1, INSN_ADDI, 1'b1, 5'd3, 32'h0);
    step();
    clear_inputs();
    drv(1, NOP_EXIT, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    expect_event("exit1", 2'd1, 2'd0, 32'h0);
    check("exit1_term", core_terminated, 4'b0010);
    drv(1, NOP_PUTC, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    drv(3, INSN_ADDI, 1'b1, 5'd3, 32'h7);
    step();
    check("exit1_not_done", all_done, 0);
    clear_inputs();
    drv(3, NOP_EXIT, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    expect_event("exit3", 2'd3, 2'd0, 32'h7);
    n = 0;
    while (!all_done && n < 10) begin
      step();
      n++;
    end
    check("exit_all_done", all_done, 1);
    check("exit_term", core_terminated, 4'b1010);
    check("exit_drained", evt_valid, 0);

    // Reset mid-operation discards pending events and sticky flags
    do_reset();
    drv(0, NOP_EXIT, 1'b0, 5'd0, 32'h0);
    drv(2, NOP_PUTC, 1'b0, 5'd0, 32'h0);
    step();
    clear_inputs();
    step();
    check("midrst_pending", evt_valid, 1);
    check("midrst_term_pre", core_terminated, 4'b0001);
    rst = 1'b1;
    evt_ready = 1'b1;
    step();
    rst = 1'b0;
    evt_ready = 1'b0;
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_term", core_terminated, 0);
    step();
    check("midrst_after", evt_valid, 0);

    // Watchdog: fires after 100 idle cycles, exactly once
    do_reset();
    repeat (99) step();
    check("wd_99_timeout", timeout, 0);
    check("wd_99_evt", evt_valid, 0);
    step();
    check("wd_100_timeout", timeout, 1);
    check("wd_evt_valid", evt_valid, 1);
    check("wd_evt_core", evt_core, 0);
    check("wd_evt_type", evt_type, 2'd3);
    check("wd_evt_data", evt_data, 32'd100);
    evt_ready = 1'b1;
    step();
    check("wd_popped", evt_valid, 0);
    extra = 0;
    repeat (150) begin
      step();
      if (evt_valid) extra++;
    end
    check("wd_no_second", extra, 0);
    check("wd_sticky", timeout, 1);

    // Reset mid-wait restarts the watchdog count
    do_reset();
    repeat (50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wdrst_timeout", timeout, 0);
    repeat (99) step();
    check("wdrst_99", timeout, 0);
    step();
    check("wdrst_100", timeout, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicore_trace_monitor.md
MULTICORE_TRACE_MONITOR -- requirements
Module: multicore_trace_monitor

Interface
REQ-001 The parameter list SHALL be:
- NUM_CORES, 1, number of traced cores (1..64).
- FIFO_DEPTH, 4, per-core event FIFO entries (power of two, >=2).
- TERM_CROSS_NUM, NUM_CORES, exited cores required for all_done.
- TIMEOUT_CYCLES, 0, idle-retire watchdog limit; 0 disables the watchdog.

REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- trace_valid, in, NUM_CORES, per-core instruction retire strobe.
- trace_insn, in, NUM_CORES x 32, retired instruction word.
- trace_wben, in, NUM_CORES, register write-back enable.
- trace_wbreg, in, NUM_CORES x 5, write-back register index.
- trace_wbdata, in, NUM_CORES x 32, write-back data.
- evt_valid, out, 1, event available.
- evt_ready, in, 1, consumer accepts event.
- evt_core, out, clog2(NUM_CORES) (min 1), source core of event.
- evt_type, out, 2, event type: EXIT=0, PUTC=1, REPORT=2, TIMEOUT=3.
- evt_data, out, 32, event payload.
- core_terminated, out, NUM_CORES, sticky per-core exit flag.
- overflow, out, NUM_CORES, sticky per-core event-drop flag.
- all_done, out, 1, termination criterion met and events drained.
- timeout, out, 1, sticky watchdog-expired flag.

Function
REQ-003 Per core, the block SHALL keep a shadow r3, updated to trace_wbdata when trace_valid & trace_wben & trace_wbreg==3.
REQ-004 A retire SHALL be an l.nop when insn[31:24]==8'h15; K = insn[15:0]. K=1 is EXIT, K=4 is PUTC, K=2 is REPORT, and any other K is ignored.
REQ-005 An event payload SHALL be the shadow r3 value present before that cycle's write-back. For PUTC, the payload is zero-extended r3[7:0].
REQ-006 A detected event SHALL be pushed into that core's FIFO in the cycle after retire (one-cycle capture register).
REQ-007 EXIT SHALL set core_terminated[i] in the same cycle as its push. Later retires of a terminated core are ignored until reset.
REQ-008 A push into a full FIFO SHALL drop the event and set overflow[i]. The FIFO contents are unaffected.
REQ-009 Output arbitration SHALL be round-robin:
- Search starts at last_grant+1, wrapping from NUM_CORES-1 to 0, and grants the first non-empty FIFO.
- evt_valid equals OR of all FIFOs non-empty.
REQ-010 While evt_valid & !evt_ready, the grant, evt_core, evt_type and evt_data SHALL hold stable.
REQ-011 On evt_valid & evt_ready, the granted FIFO SHALL pop and last_grant SHALL update to the granted core. A push and a pop on the same FIFO in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-012 The watchdog, when TIMEOUT_CYCLES>0:
- Counter clears on any trace_valid bit and otherwise increments, saturating.
- On reaching TIMEOUT_CYCLES, timeout is set and one TIMEOUT event (evt_core=0, data=counter value) is queued through a dedicated one-entry slot.
- The TIMEOUT slot has lowest arbitration priority.
- timeout asserts at most once per reset.
REQ-013 all_done SHALL be registered and assert when popcount(core_terminated) >= TERM_CROSS_NUM, all FIFOs and capture registers are empty, and evt_valid is 0.
REQ-014 Simultaneous retires on all cores in one cycle SHALL each be captured without loss, given non-full FIFOs.

Reset
REQ-015 On rst, the block SHALL clear:
- outputs: evt_valid, core_terminated, overflow, all_done, timeout.
- internal state: shadow r3, FIFO pointers, capture registers, the watchdog counter and last_grant (last_grant resets to NUM_CORES-1, so core 0 is served first).
REQ-016 A rst asserted mid-operation SHALL discard pending events in the next cycle, regardless of evt_ready.

Structure
REQ-017 The evt_type enumeration and the l.nop opcode/K constants SHALL reside in the shared optimsoc package.
REQ-018 The per-core FIFO SHALL be a sub-module, trace_event_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty), instantiated NUM_CORES times in a generate loop.

Verification
REQ-019 Single core: write r3=0x41, then retire 0x15000004. Expected: one PUTC event with core=0, data=0x41; all_done stays 0.
REQ-020 NUM_CORES=4, all cores retire PUTC together with evt_ready=1. Expected: events emitted in core order 0,1,2,3 on consecutive cycles.
REQ-021 evt_ready=0 for 10 cycles with events pending. Expected: evt_* stable throughout, then one pop per ready cycle.
REQ-022 FIFO_DEPTH=4, 5 PUTC events on core 2 with evt_ready=0. Expected: overflow[2]=1, and exactly 4 events drained afterwards.
REQ-023 TERM_CROSS_NUM=2, core 1 EXIT with r3=0, then core 3 EXIT with r3=7. Expected: EXIT events carry data 0 and 7, core_terminated=4'b1010, and all_done=1 after drain.
REQ-024 TIMEOUT_CYCLES=100 with no retires. Expected: timeout=1 at cycle 100, one TIMEOUT event, no second event; rst mid-wait clears everything.
